// File: rtl/writeback_regfile_if.sv
// Writeback-stage bundle: the WB pipeline register fields, the decode read ports
// and the debug/hazard outputs of the register file.
interface writeback_regfile_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 32
);
    logic [XLEN-1:0]   ALUResultW;
    logic [XLEN-1:0]   ReadDataW;
    logic [XLEN-1:0]   PCPlus4W;
    logic [ADDR_W-1:0] RdW;
    logic [2:0]        controlW;
    logic [ADDR_W-1:0] A1;
    logic [ADDR_W-1:0] A2;
    logic [XLEN-1:0]   RD1;
    logic [XLEN-1:0]   RD2;
    logic [XLEN-1:0]   ResultW;
    logic              RegWriteWo;
    logic [CNT_W-1:0]  wb_count;
    logic              illegal_src;

    modport master (
        output ALUResultW, ReadDataW, PCPlus4W, RdW, controlW, A1, A2,
        input  RD1, RD2, ResultW, RegWriteWo, wb_count, illegal_src
    );

    modport slave (
        input  ALUResultW, ReadDataW, PCPlus4W, RdW, controlW, A1, A2,
        output RD1, RD2, ResultW, RegWriteWo, wb_count, illegal_src
    );
endinterface

// File: rtl/writeback_regfile.sv
// Writeback stage: result select, 32x32 integer register file with x0 hardwired
// to zero, two combinational read ports with same-cycle write bypass, debug state.
module writeback_regfile #(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 32
) (
    input logic              CLK,
    input logic              RST,
    writeback_regfile_if.slave wb
);
    logic [XLEN-1:0]  regs [0:NREG-1];
    logic [CNT_W-1:0] wb_count_q;
    logic             illegal_q;
    logic [XLEN-1:0]  result;
    logic             reg_write;
    logic [1:0]       result_src;
    logic             we;
    logic             src_illegal;

    assign reg_write   = wb.controlW[2];
    assign result_src  = wb.controlW[1:0];
    assign src_illegal = (result_src == 2'b11);
    assign we          = reg_write && (wb.RdW != '0) && !src_illegal;

    always_comb begin
        result = '0;
        case (result_src)
            2'b00:   result = wb.ALUResultW;
            2'b01:   result = wb.ReadDataW;
            2'b10:   result = wb.PCPlus4W;
            default: result = '0;
        endcase
    end

    // Reads bypass the array when the same register is being committed this cycle;
    // both the bypass and the array are masked while reset is held.
    assign wb.RD1 = (RST || wb.A1 == '0) ? '0 :
                    (we && wb.A1 == wb.RdW) ? result : regs[wb.A1];
    assign wb.RD2 = (RST || wb.A2 == '0) ? '0 :
                    (we && wb.A2 == wb.RdW) ? result : regs[wb.A2];

    assign wb.ResultW     = result;
    assign wb.RegWriteWo  = we;
    assign wb.wb_count    = wb_count_q;
    assign wb.illegal_src = illegal_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i[ADDR_W-1:0]] <= '0;
            end
            wb_count_q <= '0;
            illegal_q  <= 1'b0;
        end else begin
            if (we) begin
                regs[wb.RdW] <= result;
                wb_count_q   <= wb_count_q + CNT_W'(1);
            end
            // Sticky until reset; the suppressed write itself is handled by we.
            if (reg_write && src_illegal) begin
                illegal_q <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_writeback_regfile.sv
// Directed bench for writeback_regfile: reset, result select, x0, bypass,
// illegal ResultSrc and 4-bit counter wrap.
module tb_writeback_regfile;
    logic CLK;
    logic RST;
    int   n_chk;
    int   n_pass;

    writeback_regfile_if #(.XLEN(32), .ADDR_W(5), .CNT_W(4)) wbif ();

    writeback_regfile #(.XLEN(32), .NREG(32), .ADDR_W(5), .CNT_W(4)) dut (
        .CLK (CLK),
        .RST (RST),
        .wb  (wbif.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        if (obs === exp_v) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp_v);
        end
    endtask

    task automatic set_wb(input logic [2:0] ctl, input logic [4:0] rd,
                          input logic [31:0] alu, input logic [31:0] rdat,
                          input logic [31:0] pc, input logic [4:0] a1,
                          input logic [4:0] a2);
        @(negedge CLK);
        wbif.controlW   = ctl;
        wbif.RdW        = rd;
        wbif.ALUResultW = alu;
        wbif.ReadDataW  = rdat;
        wbif.PCPlus4W   = pc;
        wbif.A1         = a1;
        wbif.A2         = a2;
        #1;
    endtask

    task automatic edge_step();
        @(posedge CLK);
        #1;
        wbif.controlW = 3'b000;
        #1;
    endtask

    task automatic legal_write(input logic [4:0] rd, input logic [31:0] val);
        set_wb(3'b100, rd, val, 32'h0, 32'h0, rd, 5'd0);
        edge_step();
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        RST    = 1'b1;
        wbif.controlW   = 3'b000;
        wbif.RdW        = 5'd0;
        wbif.ALUResultW = 32'h0;
        wbif.ReadDataW  = 32'h0;
        wbif.PCPlus4W   = 32'h0;
        wbif.A1         = 5'd1;
        wbif.A2         = 5'd31;
        #12;
        chk("reset_rd1", wbif.RD1, 32'h0);
        chk("reset_cnt", 32'(wbif.wb_count), 32'h0);
        chk("reset_ill", 32'(wbif.illegal_src), 32'h0);
        @(negedge CLK);
        RST = 1'b0;

        // 1: fill x1..x31, then asynchronous reset in the middle of a cycle
        for (int i = 1; i < 32; i++) begin
            legal_write(5'(i), 32'hA5A5_0000 + 32'(i));
        end
        set_wb(3'b000, 5'd0, 32'h0, 32'h0, 32'h0, 5'd31, 5'd1);
        chk("fill_x31", wbif.RD1, 32'hA5A5_001F);
        chk("fill_x1", wbif.RD2, 32'hA5A5_0001);
        chk("fill_cnt", 32'(wbif.wb_count), 32'd15);
        @(negedge CLK);
        #2;
        RST = 1'b1;
        #1;
        chk("arst_rd1", wbif.RD1, 32'h0);
        chk("arst_rd2", wbif.RD2, 32'h0);
        chk("arst_cnt", 32'(wbif.wb_count), 32'h0);
        wbif.controlW   = 3'b100;
        wbif.RdW        = 5'd4;
        wbif.ALUResultW = 32'h4444_4444;
        wbif.A1         = 5'd4;
        #1;
        chk("arst_nobypass", wbif.RD1, 32'h0);
        @(negedge CLK);
        RST = 1'b0;
        wbif.controlW = 3'b000;
        #1;
        chk("post_rst_x4", wbif.RD1, 32'h0);
        chk("post_rst_x31", wbif.RD2, 32'h0);

        // 2: result select and commit
        legal_write(5'd5, 32'h1234_5678);
        set_wb(3'b000, 5'd0, 32'h0, 32'h0, 32'h0, 5'd5, 5'd0);
        chk("wr_x5", wbif.RD1, 32'h1234_5678);
        chk("wr_cnt1", 32'(wbif.wb_count), 32'd1);
        set_wb(3'b101, 5'd6, 32'h0000_0001, 32'hCAFE_F00D, 32'h0000_1004, 5'd0, 5'd0);
        chk("sel_mem", wbif.ResultW, 32'hCAFE_F00D);
        edge_step();
        set_wb(3'b110, 5'd8, 32'h0000_0001, 32'hCAFE_F00D, 32'h0000_1004, 5'd6, 5'd0);
        chk("sel_pc", wbif.ResultW, 32'h0000_1004);
        chk("rd_x6", wbif.RD1, 32'hCAFE_F00D);
        edge_step();
        set_wb(3'b011, 5'd9, 32'h0000_0001, 32'hCAFE_F00D, 32'h0000_1004, 5'd8, 5'd9);
        chk("sel_11_zero", wbif.ResultW, 32'h0);
        chk("rd_x8", wbif.RD1, 32'h0000_1004);
        edge_step();
        chk("store_no_ill", 32'(wbif.illegal_src), 32'h0);
        chk("cnt3", 32'(wbif.wb_count), 32'd3);

        // 3: x0 is never written
        set_wb(3'b100, 5'd0, 32'hFFFF_FFFF, 32'h0, 32'h0, 5'd0, 5'd0);
        chk("x0_we", 32'(wbif.RegWriteWo), 32'h0);
        chk("x0_rd_pre", wbif.RD1, 32'h0);
        edge_step();
        chk("x0_rd_post", wbif.RD1, 32'h0);
        chk("x0_cnt", 32'(wbif.wb_count), 32'd3);

        // 4: write-through bypass
        legal_write(5'd7, 32'h1111_1111);
        set_wb(3'b000, 5'd7, 32'hDEAD_BEEF, 32'h0, 32'h0, 5'd7, 5'd7);
        chk("nobyp_rd1", wbif.RD1, 32'h1111_1111);
        chk("nobyp_rd2", wbif.RD2, 32'h1111_1111);
        edge_step();
        set_wb(3'b100, 5'd7, 32'hDEAD_BEEF, 32'h0, 32'h0, 5'd7, 5'd7);
        chk("byp_we", 32'(wbif.RegWriteWo), 32'h1);
        chk("byp_rd1", wbif.RD1, 32'hDEAD_BEEF);
        chk("byp_rd2", wbif.RD2, 32'hDEAD_BEEF);
        wbif.A2 = 5'd5;
        #1;
        chk("byp_other", wbif.RD2, 32'h1234_5678);
        edge_step();
        chk("byp_commit", wbif.RD1, 32'hDEAD_BEEF);
        chk("byp_cnt", 32'(wbif.wb_count), 32'd5);

        // 5: illegal ResultSrc is suppressed and sticky
        legal_write(5'd3, 32'h0000_0333);
        set_wb(3'b111, 5'd3, 32'h3333_3333, 32'h0, 32'h0, 5'd3, 5'd0);
        chk("ill_result", wbif.ResultW, 32'h0);
        chk("ill_we", 32'(wbif.RegWriteWo), 32'h0);
        chk("ill_pre", 32'(wbif.illegal_src), 32'h0);
        edge_step();
        chk("ill_set", 32'(wbif.illegal_src), 32'h1);
        chk("ill_x3", wbif.RD1, 32'h0000_0333);
        chk("ill_cnt", 32'(wbif.wb_count), 32'd6);
        for (int i = 10; i < 20; i++) begin
            legal_write(5'(i), 32'(i));
        end
        chk("ill_held", 32'(wbif.illegal_src), 32'h1);
        chk("cnt_wrap16", 32'(wbif.wb_count), 32'd0);
        @(negedge CLK);
        RST = 1'b1;
        #1;
        chk("ill_clear", 32'(wbif.illegal_src), 32'h0);
        @(negedge CLK);
        RST = 1'b0;

        // 6: counter wrap with stores and bubbles interleaved
        for (int k = 0; k < 17; k++) begin
            legal_write(5'd20 + 5'(k % 4), 32'h600 + 32'(k));
            set_wb(3'b001, 5'd9, 32'h9, 32'h9, 32'h9, 5'd0, 5'd0);
            edge_step();
            set_wb(3'b000, 5'd0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0);
            edge_step();
            if (k == 14) chk("cnt15", 32'(wbif.wb_count), 32'd15);
            if (k == 15) chk("cnt16_wrap", 32'(wbif.wb_count), 32'd0);
        end
        chk("cnt17", 32'(wbif.wb_count), 32'd1);
        set_wb(3'b000, 5'd0, 32'h0, 32'h0, 32'h0, 5'd20, 5'd9);
        chk("last_x20", wbif.RD1, 32'h0000_0610);
        chk("store_x9", wbif.RD2, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
